// File: rtl/ntt_pkg.sv
// Shared types and modular arithmetic for the SDF NTT pipeline.
// The *_DEF constants size the shared types and set the default module parameters.
package ntt_pkg;

   localparam int unsigned W_DEF     = 32;
   localparam int unsigned Q_DEF     = 7681;
   localparam int unsigned N_DEF     = 8;
   localparam int unsigned LOG_N_DEF = $clog2(N_DEF);

   typedef logic [W_DEF-1:0] word_t;

   typedef struct packed {
      logic                 v;
      logic [LOG_N_DEF-1:0] p;
   } tag_t;

   function automatic word_t mod_add(input word_t a, input word_t b, input word_t q);
      logic [W_DEF:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) s = s - {1'b0, q};
      return s[W_DEF-1:0];
   endfunction

   // A borrow wraps modulo 2^(W+1); adding q brings the result back into [0, q).
   function automatic word_t mod_sub(input word_t a, input word_t b, input word_t q);
      logic [W_DEF:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (a < b) d = d + {1'b0, q};
      return d[W_DEF-1:0];
   endfunction

   function automatic word_t mod_mul(input word_t a, input word_t b, input word_t q);
      logic [2*W_DEF-1:0] prod;
      prod = {{W_DEF{1'b0}}, a} * {{W_DEF{1'b0}}, b};
      return W_DEF'(prod % {{W_DEF{1'b0}}, q});
   endfunction

   function automatic logic [LOG_N_DEF-1:0] bitreverse(input logic [LOG_N_DEF-1:0] v);
      logic [LOG_N_DEF-1:0] r;
      for (int i = 0; i < LOG_N_DEF; i++) r[i] = v[LOG_N_DEF-1-i];
      return r;
   endfunction

endpackage

// File: rtl/sdf_stage.sv
// One radix-2 DIF stage: tagged feedback delay line, butterfly/pass mux,
// twiddle address generation and a registered modular multiply.
module sdf_stage
   import ntt_pkg::*;
#(
   parameter int unsigned  W       = W_DEF,
   parameter int unsigned  MODULUS = Q_DEF,
   parameter int unsigned  N       = N_DEF,
   parameter int unsigned  S       = 0,
   localparam int unsigned LOG_N   = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     x_i,
   input  tag_t             tag_i,
   output logic [LOG_N-2:0] tw_addr_o,
   input  logic [W-1:0]     tw_data_i,
   output logic [W-1:0]     y_o,
   output tag_t             tag_o,
   output logic             busy_o
);

   localparam int               D     = N >> (S + 1);
   localparam int               HBIT  = LOG_N - 1 - S;
   localparam bit               LAST  = (S == LOG_N - 1);
   localparam logic [W-1:0]     QW    = W'(MODULUS);
   localparam logic [W-1:0]     ONE   = W'(1);
   localparam logic [LOG_N-1:0] PMASK = LOG_N'(D - 1);

   logic [W-1:0] dl_data_q [D];
   tag_t         dl_tag_q  [D];
   logic [W-1:0] head_data, push_data, mux_data, factor, y_d, y_q;
   tag_t         head_tag, push_tag, tag_d, tag_q;

   assign head_data = dl_data_q[D-1];
   assign head_tag  = dl_tag_q[D-1];

   // NOTE: every output of this block is given a default first, so no path can infer a latch.
   always_comb begin
      mux_data  = head_data;
      tag_d     = head_tag;
      push_data = x_i;
      push_tag  = tag_i;
      if (tag_i.v && tag_i.p[HBIT]) begin
         mux_data  = mod_add(head_data, x_i, QW);
         push_data = mod_sub(head_data, x_i, QW);
      end
      factor = (LAST || !tag_d.p[HBIT]) ? ONE : tw_data_i;
      y_d    = mod_mul(mux_data, factor, QW);
   end

   // Differences of sub-block M use omega_M^j = omega^(j << S), j = p mod (M/2).
   assign tw_addr_o = (LOG_N-1)'((tag_d.p & PMASK) << S);

   // NOTE: data words are qualified by their tag valid bits, so the data delay line needs no reset.
   always_ff @(posedge clk) begin
      dl_data_q[0] <= push_data;
      for (int i = 1; i < D; i++) dl_data_q[i] <= dl_data_q[i-1];
   end

   // NOTE: non-blocking assignments make every tap take its neighbour's previous-cycle value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < D; i++) dl_tag_q[i] <= '0;
         tag_q <= '0;
         y_q   <= '0;
      end else begin
         dl_tag_q[0] <= push_tag;
         for (int i = 1; i < D; i++) dl_tag_q[i] <= dl_tag_q[i-1];
         tag_q <= tag_d;
         y_q   <= y_d;
      end
   end

   always_comb begin
      busy_o = tag_q.v;
      for (int i = 0; i < D; i++) busy_o = busy_o | dl_tag_q[i].v;
   end

   assign y_o   = y_q;
   assign tag_o = tag_q;

endmodule

// File: rtl/ntt_sdf_pipeline.sv
// N-point radix-2 DIF NTT as a single-path delay-feedback pipeline:
// natural-order input, bit-reversed output tagged with its bin index.
module ntt_sdf_pipeline
   import ntt_pkg::*;
#(
   parameter int unsigned  W       = W_DEF,
   parameter int unsigned  MODULUS = Q_DEF,
   parameter int unsigned  N       = N_DEF,
   localparam int unsigned LOG_N   = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [W-1:0]     in_data,
   input  logic             write_en,
   input  logic [LOG_N-2:0] write_addr,
   input  logic [W-1:0]     write_data,
   output logic             full_ram,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic [LOG_N-1:0] out_idx,
   output logic             busy
);

   logic [LOG_N-1:0] wcnt_q, wcnt_d;
   logic [LOG_N-1:0] pos_q, pos_d;
   logic [W-1:0]     ram_q [N/2];
   logic             accept;

   logic [W-1:0]     stg_data [LOG_N+1];
   tag_t             stg_tag  [LOG_N+1];
   logic [LOG_N-2:0] tw_addr  [LOG_N];
   logic [W-1:0]     tw_data  [LOG_N];
   logic [LOG_N-1:0] stg_busy;

   assign full_ram = (wcnt_q == LOG_N'(N / 2));
   assign accept   = in_valid && full_ram;

   // Any non-accepting cycle restarts the frame, which also recovers from mid-frame gaps.
   always_comb begin
      wcnt_d = wcnt_q;
      if (write_en && !full_ram) wcnt_d = wcnt_q + LOG_N'(1);
      pos_d = accept ? pos_q + LOG_N'(1) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q <= '0;
         pos_q  <= '0;
      end else begin
         wcnt_q <= wcnt_d;
         pos_q  <= pos_d;
      end
   end

   // Twiddle RAM is cleared on reset, so it is built from flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N / 2; i++) ram_q[i] <= '0;
      end else if (write_en) begin
         ram_q[write_addr] <= write_data;
      end
   end

   assign stg_data[0] = in_data;

   always_comb begin
      stg_tag[0]   = '0;
      stg_tag[0].v = accept;
      stg_tag[0].p = pos_q;
   end

   for (genvar s = 0; s < LOG_N; s++) begin : g_stage
      sdf_stage #(
         .W       (W),
         .MODULUS (MODULUS),
         .N       (N),
         .S       (s)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .x_i       (stg_data[s]),
         .tag_i     (stg_tag[s]),
         .tw_addr_o (tw_addr[s]),
         .tw_data_i (tw_data[s]),
         .y_o       (stg_data[s+1]),
         .tag_o     (stg_tag[s+1]),
         .busy_o    (stg_busy[s])
      );
      assign tw_data[s] = ram_q[tw_addr[s]];
   end

   assign out_valid = stg_tag[LOG_N].v;
   assign out_data  = stg_data[LOG_N];
   assign out_idx   = bitreverse(stg_tag[LOG_N].p);
   assign busy      = |stg_busy;

endmodule

// File: tb/tb_ntt_sdf_pipeline.sv
// Scoreboard bench for ntt_sdf_pipeline (N=8, q=7681, omega=1213).
module tb_ntt_sdf_pipeline;

   localparam int unsigned W   = 32;
   localparam int unsigned Q   = 7681;
   localparam int unsigned LAT = 10;
   // Hand-computed powers of the primitive 8th root omega = 1213 mod 7681.
   localparam int unsigned PW [8] = '{1, 1213, 4298, 5756, 7680, 6468, 3383, 1925};

   typedef int unsigned frame_t [8];
   typedef struct {
      int unsigned cyc;
      int unsigned idx;
      int unsigned data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          write_en;
   logic [1:0]    write_addr;
   logic [W-1:0]  write_data;
   logic          full_ram;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic [2:0]    out_idx;
   logic          busy;

   int unsigned   cyc = 0;
   int            errors = 0;
   int            checks = 0;
   exp_t          sb [$];
   exp_t          mon_e;

   ntt_sdf_pipeline #(.W(W), .MODULUS(Q), .N(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .write_en   (write_en),
      .write_addr (write_addr),
      .write_data (write_data),
      .full_ram   (full_ram),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int unsigned brev3(input int unsigned v);
      return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
   endfunction

   function automatic frame_t impulse_in(input int unsigned a, input int unsigned n);
      frame_t f;
      for (int i = 0; i < 8; i++) f[i] = (i == n) ? a : 0;
      return f;
   endfunction

   // X[k] = a * omega^(n*k), listed in output order (position p holds bin bitrev(p)).
   function automatic frame_t impulse_out(input int unsigned a, input int unsigned n);
      frame_t f;
      for (int p = 0; p < 8; p++) f[p] = (a * PW[(n * brev3(p)) % 8]) % Q;
      return f;
   endfunction

   function automatic frame_t const_in(input int unsigned c);
      frame_t f;
      for (int i = 0; i < 8; i++) f[i] = c;
      return f;
   endfunction

   function automatic frame_t const_out(input int unsigned c);
      frame_t f;
      for (int p = 0; p < 8; p++) f[p] = (p == 0) ? (8 * c) % Q : 0;
      return f;
   endfunction

   // Monitor: every out_valid must match the oldest expectation, including its cycle.
   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got idx %0d data %0d at cycle %0d, expected no output",
                     out_idx, out_data, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("out_cycle", cyc, mon_e.cyc);
            check("out_idx", out_idx, mon_e.idx);
            check("out_data", out_data, mon_e.data);
         end
      end
   end

   task automatic write_tw(input int unsigned a, input int unsigned d);
      @(posedge clk); #1;
      write_en   = 1'b1;
      write_addr = 2'(a);
      write_data = W'(d);
      @(posedge clk); #1;
      write_en = 1'b0;
   endtask

   task automatic load_twiddles(input int count);
      for (int j = 0; j < count; j++) write_tw(j, PW[j]);
   endtask

   task automatic send_frame(input frame_t x, input frame_t e);
      exp_t item;
      for (int p = 0; p < 8; p++) begin
         @(posedge clk); #1;
         if (p == 0) begin
            for (int k = 0; k < 8; k++) begin
               item.cyc  = cyc + LAT + k;
               item.idx  = brev3(k);
               item.data = e[k];
               sb.push_back(item);
            end
         end
         in_valid = 1'b1;
         in_data  = W'(x[p]);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_data  = '0;
      end
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 200; i++) begin
         if (sb.size() == 0 && !busy) break;
         @(posedge clk); #1;
      end
      check("drain_done", (sb.size() == 0 && !busy) ? 1 : 0, 1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_idx"}, out_idx, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_full_ram"}, full_ram, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      write_en   = 1'b0;
      write_addr = '0;
      write_data = '0;
      @(posedge clk); @(posedge clk); #1;
      check_reset_state("reset");
      rst = 1'b0;

      // Only three twiddles loaded: input must be dropped entirely.
      load_twiddles(3);
      check("full_after_3_writes", full_ram, 0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         in_valid = (i < 8);
         in_data  = 1;
         if (i % 4 == 3) check("busy_while_not_full", busy, 0);
      end
      in_valid = 1'b0;
      write_tw(3, PW[3]);
      check("full_after_4_writes", full_ram, 1);

      // Impulse and constant back-to-back, gap of 20 cycles, then impulse at position 4.
      send_frame(impulse_in(1, 0), impulse_out(1, 0));
      check("busy_in_flight", busy, 1);
      send_frame(const_in(1), const_out(1));
      idle(20);
      send_frame(impulse_in(1, 4), impulse_out(1, 4));
      idle(1);
      drain();

      // Twiddle-dependent frames and wrap-around arithmetic with q-1 operands.
      send_frame(impulse_in(1, 1), impulse_out(1, 1));
      send_frame(impulse_in(7680, 3), impulse_out(7680, 3));
      send_frame(const_in(7680), const_out(7680));
      send_frame(impulse_in(7680, 0), impulse_out(7680, 0));
      idle(1);
      drain();

      // Reset on the fifth sample of a frame discards it and clears the twiddle RAM.
      for (int p = 0; p < 5; p++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = (p == 0) ? 1 : 0;
         if (p == 4) rst = 1'b1;
      end
      @(posedge clk); #1;
      check_reset_state("midframe_reset");
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      idle(15);
      load_twiddles(4);
      send_frame(impulse_in(1, 1), impulse_out(1, 1));
      idle(1);
      drain();
      check("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
